// File: rtl/onehot_sequencer_if.sv
// Load channel for onehot_sequencer: valid/ready handshake carrying the
// start index, sequencing mode and step period.
interface onehot_sequencer_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [1:0]       mode;
    logic [DIV_W-1:0] step_div;

    modport master (
        output in_valid,
        output sel,
        output mode,
        output step_div,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  mode,
        input  step_div,
        output in_ready
    );
endinterface

// File: rtl/onehot_sequencer.sv
// Registered binary-to-one-hot decoder with hold, scan (up/down, wrapping)
// and one-shot sweep modes. Loads arrive on a valid/ready channel; a
// prescaler sets how many cycles each index is held while sequencing.
module onehot_sequencer #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    onehot_sequencer_if.slave     ld,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  wrap,
    output logic                  done
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN,
        SWEEP
    } state_e;

    typedef enum logic [1:0] {
        M_DECODE    = 2'b00,
        M_SCAN_UP   = 2'b01,
        M_SCAN_DOWN = 2'b10,
        M_ONESHOT   = 2'b11
    } mode_e;

    state_e           state;
    mode_e            mode_in;
    logic             scan_down;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] div_q;
    logic             accept;
    logic             expiry;
    logic             wraps;
    logic [SEL_W-1:0] idx_nxt;

    assign ld.in_ready = en && (state != SWEEP);
    assign busy        = (state != IDLE);

    // Handshake, step expiry and next-index decode.
    always_comb begin
        mode_in = mode_e'(ld.mode);
        accept  = ld.in_valid && ld.in_ready;
        expiry  = (presc == div_q);
        idx_nxt = scan_down ? (idx - IDX_ONE) : (idx + IDX_ONE);
        wraps   = scan_down ? (idx == '0) : (idx == '1);
    end

    // Sequencer state, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            idx       <= '0;
            presc     <= '0;
            div_q     <= '0;
            scan_down <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            out   <= '0;
            idx   <= '0;
            presc <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                // A load overrides any expiry in the same cycle, so no pulse is raised.
                idx       <= ld.sel;
                out       <= OUT_ONE << ld.sel;
                presc     <= '0;
                div_q     <= ld.step_div;
                scan_down <= (mode_in == M_SCAN_DOWN);
                case (mode_in)
                    M_DECODE:    state <= HOLD;
                    M_SCAN_UP:   state <= SCAN;
                    M_SCAN_DOWN: state <= SCAN;
                    default:     state <= SWEEP;
                endcase
            end else begin
                case (state)
                    SCAN: begin
                        if (expiry) begin
                            presc <= '0;
                            idx   <= idx_nxt;
                            out   <= OUT_ONE << idx_nxt;
                            wrap  <= wraps;
                        end else begin
                            presc <= presc + DIV_ONE;
                        end
                    end
                    SWEEP: begin
                        if (expiry) begin
                            presc <= '0;
                            if (idx == '1) begin
                                out   <= '0;
                                idx   <= '0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                idx <= idx_nxt;
                                out <= OUT_ONE << idx_nxt;
                            end
                        end else begin
                            presc <= presc + DIV_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Registered, parametrised binary-to-one-hot decoder with sequencing modes. Generalises the combinational 3-to-8 decoder in three ways: output width is set by a parameter, outputs are registered, and the index can either be held, scanned up or down with wrap-around, or swept once to the top. It drives row/lane-select, LED-walk and channel-strobe logic. Index loads use a valid/ready handshake.

## Interface
- SEL_W, default 3: index width. Output width OUT_W = 2**SEL_W.
- DIV_W, default 8: step-prescaler width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable. Low clears the block synchronously.
- in_valid  in  1  load request.
- in_ready  out  1  load accept. Combinational: en && state!=SWEEP.
- sel  in  SEL_W  start/hold index. Sampled on accept.
- mode  in  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 ONESHOT. Sampled on accept.
- step_div  in  DIV_W  step period minus 1. Sampled on accept.
- out  out  OUT_W  one-hot output, registered. Equals 1<<idx when active, else 0.
- idx  out  SEL_W  current index, registered.
- busy  out  1  high in any state other than IDLE.
- wrap  out  1  one-cycle pulse on the cycle idx wraps (SCAN states).
- done  out  1  one-cycle pulse when a ONESHOT sweep finishes.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge.
- On accept:
  - idx <= sel, prescaler <= 0, out <= 1<<sel.
  - mode and step_div are latched.
  - Next state: DECODE->HOLD, SCAN_UP/SCAN_DOWN->SCAN, ONESHOT->SWEEP.
- States:
  - IDLE: out=0. Waits for an accept.
  - HOLD: out and idx held. A new accept reloads with any mode.
  - SCAN: prescaler counts 0..step_div. When it expires, the prescaler returns to 0 and idx steps by +1 (UP) or -1 (DOWN), modulo OUT_W.
    - Wrap means OUT_W-1 -> 0 (UP) or 0 -> OUT_W-1 (DOWN).
    - wrap=1 in the same cycle the wrapped idx appears on out.
    - A new accept reloads everything.
  - SWEEP: idx steps +1 on each expiry. At expiry with idx==OUT_W-1: out <= 0, idx <= 0, done=1 for one cycle, then IDLE. in_ready=0 throughout SWEEP.
- Arithmetic: idx wraps naturally at SEL_W bits. The prescaler is DIV_W bits and is compared against the latched step_div. step_div=0 gives one step per cycle.
- Priority, highest first: rst_n low > en low > accept > step expiry.
- en low at an edge: state <= IDLE; out, idx, prescaler, wrap and done <= 0. in_ready=0 while en is low.
- Accept and step expiry in the same cycle: the accept wins and no wrap or done pulse is produced.
- The sel, mode and step_div inputs are ignored outside accept cycles.

## Timing
- Reset (async assert): state=IDLE; out=0, idx=0, busy=0, wrap=0, done=0, prescaler=0; in_ready=en.
- Reset deassertion is assumed synchronised externally. The first accept is possible on the first edge after release.
- Load latency is 1 cycle: for an accept at edge k, out = 1<<sel after edge k.
- Step cadence: the first step occurs at edge k+step_div+1. Each index is then held for exactly step_div+1 cycles.
- ONESHOT from sel=s: out is zero after edge k+(OUT_W-s)*(step_div+1). done is high in that same cycle.
- wrap and done are registered. Each is high for exactly one cycle.

## Test plan
- DECODE, SEL_W=3: accept sel=5 -> out=8'h20 from the next cycle and held for 20+ cycles, busy=1, wrap=0. Then accept sel=2 -> out=8'h04 on the next cycle.
- SCAN_UP, step_div=0, sel=6 -> out sequence 8'h40, 8'h80, 8'h01, 8'h02. wrap=1 only on the 8'h01 cycle.
- SCAN_DOWN, step_div=2, sel=1 -> 8'h02 for 3 cycles, 8'h01 for 3 cycles, then 8'h80 with wrap=1 on its first cycle.
- ONESHOT, step_div=0, sel=5 -> 8'h20, 8'h40, 8'h80, then 8'h00 with done=1 and busy=0. in_ready=0 during the sweep and in_valid is ignored.
- Control interrupts:
  - Drop en during SCAN -> out=0, idx=0 and busy=0 after the next edge; in_ready=0.
  - Assert rst_n low mid-SWEEP -> all outputs are 0 immediately, with no clock edge needed.
- SCAN_UP, step_div=3: accept sel=7 on the exact expiry cycle of idx=7 -> out=8'h80 is reloaded, no wrap pulse, and the next step comes 4 cycles later.
